pwm_engine: RTL



---
 rtl/pwm_engine.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pwm_engine.sv
// Multi-channel PWM generator driven by the flat SPI register bus.
// Period and duty values are shadowed and only reloaded at period wrap, so register writes never glitch a pulse.
module pwm_engine #(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 8,
    parameter int NUM_CH   = 4
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      ena,
    input  logic [NUM_REGS*WIDTH-1:0] config_regs,
    output logic [NUM_CH-1:0]         pwm_out,
    output logic [WIDTH-1:0]          stat_reg
);

    logic [WIDTH-1:0] ctrl;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] duty [NUM_CH];
    logic             en;
    logic             inv;
    logic [3:0]       presc;

    assign ctrl   = config_regs[0 +: WIDTH];
    assign period = config_regs[WIDTH +: WIDTH];
    assign en     = ctrl[0];
    assign inv    = ctrl[1];
    assign presc  = ctrl[7:4];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            duty[i] = config_regs[(2+i)*WIDTH +: WIDTH];
        end
    end

    logic unused_ctrl;
    assign unused_ctrl = ^ctrl[3:2];

    generate
        if (WIDTH > 8) begin : g_ctrl_hi
            logic unused_ctrl_hi;
            assign unused_ctrl_hi = ^ctrl[WIDTH-1:8];
        end
        if (NUM_REGS > NUM_CH + 2) begin : g_spare_regs
            logic unused_regs;
            assign unused_regs = ^config_regs[NUM_REGS*WIDTH-1 : (NUM_CH+2)*WIDTH];
        end
    endgenerate

    logic [3:0]       pcnt;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] per_sh;
    logic [WIDTH-1:0] duty_sh [NUM_CH];
    logic             wrap_tgl;
    logic             sticky;

    logic              tick;
    logic              wrap;
    logic              over_any;
    logic [NUM_CH-1:0] pwm_next;

    // A wrap judges the shadows it is about to retire, so over_any looks at the old values.
    always_comb begin
        tick     = en && (pcnt == presc);
        wrap     = tick && (cnt == per_sh);
        over_any = 1'b0;
        pwm_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (duty_sh[i] > per_sh) begin
                over_any = 1'b1;
            end
            pwm_next[i] = (cnt < duty_sh[i]) ^ inv;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pcnt     <= '0;
            cnt      <= '0;
            per_sh   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh[i] <= '0;
            end
            wrap_tgl <= 1'b0;
            sticky   <= 1'b0;
            pwm_out  <= '0;
            stat_reg <= '0;
        end else if (ena) begin
            stat_reg <= {{(WIDTH-3){1'b0}}, sticky, wrap_tgl, en};
            if (!en) begin
                // While idle the shadows track the live registers so the first period after enable is current.
                pcnt    <= '0;
                cnt     <= '0;
                per_sh  <= period;
                for (int i = 0; i < NUM_CH; i++) begin
                    duty_sh[i] <= duty[i];
                end
                sticky  <= 1'b0;
                pwm_out <= {NUM_CH{inv}};
            end else begin
                pwm_out <= pwm_next;
                if (tick) begin
                    pcnt <= '0;
                end else begin
                    pcnt <= pcnt + 1'b1;
                end
                if (wrap) begin
                    cnt      <= '0;
                    per_sh   <= period;
                    for (int i = 0; i < NUM_CH; i++) begin
                        duty_sh[i] <= duty[i];
                    end
                    wrap_tgl <= ~wrap_tgl;
                    if (over_any) begin
                        sticky <= 1'b1;
                    end
                end else if (tick) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
